// File: rtl/edge_monitor_if.sv
// Bundle of the monitored signals, per-channel rules and the reporting
// outputs of edge_monitor. The bench drives the master side and the
// monitor sits on the slave side.
interface edge_monitor_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 4
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   sig_in;
    logic             sample_en;
    logic [2*NCH-1:0] mode;
    logic [NCH-1:0]   arm;
    logic [WIN_W-1:0] win_len;
    logic             cnt_clr;
    logic [SEL_W-1:0] cnt_sel;
    logic [NCH-1:0]   edge_o;
    logic [NCH-1:0]   pass_o;
    logic [NCH-1:0]   fail_o;
    logic [CNT_W-1:0] cnt_o;
    logic             err_o;

    modport master (
        output sig_in, sample_en, mode, arm, win_len, cnt_clr, cnt_sel,
        input  edge_o, pass_o, fail_o, cnt_o, err_o
    );

    modport slave (
        input  sig_in, sample_en, mode, arm, win_len, cnt_clr, cnt_sel,
        output edge_o, pass_o, fail_o, cnt_o, err_o
    );
endinterface

// File: rtl/edge_monitor.sv
// Multi-channel edge detector with saturating event counters and a
// per-channel "edge must arrive within win_len+1 enabled samples" checker.
// All pulse outputs are registered one cycle after the qualifying sample.
module edge_monitor #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 4
) (
    input logic         clk,
    input logic         rst,
    edge_monitor_if.slave bus
);
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SEL_N = 1 << SEL_W;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state [NCH];
    logic [WIN_W-1:0] rem   [NCH];
    logic [CNT_W-1:0] cnt   [NCH];
    logic [CNT_W-1:0] cnt_pad [SEL_N];

    logic [NCH-1:0] prev;
    logic [NCH-1:0] rise_p0, fall_p0, det_p0, pass_p0, fail_p0;
    logic [NCH-1:0] edge_p1, pass_p1, fail_p1;
    logic           err_p1;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign rise_p0 =  bus.sig_in & ~prev;
    assign fall_p0 = ~bus.sig_in &  prev;

    // Stage p0: apply each channel's edge rule, gated by the sample qualifier.
    always_comb begin
        det_p0 = '0;
        for (int i = 0; i < NCH; i++) begin
            case (bus.mode[2*i +: 2])
                2'b01:   det_p0[i] = bus.sample_en & rise_p0[i];
                2'b10:   det_p0[i] = bus.sample_en & fall_p0[i];
                2'b11:   det_p0[i] = bus.sample_en & (rise_p0[i] | fall_p0[i]);
                default: det_p0[i] = 1'b0;
            endcase
        end
    end

    // Window verdicts for this sample: a detection beats expiry.
    always_comb begin
        pass_p0 = '0;
        fail_p0 = '0;
        for (int i = 0; i < NCH; i++) begin
            if (state[i] == ARMED && bus.sample_en) begin
                if (det_p0[i])
                    pass_p0[i] = 1'b1;
                else if (rem[i] == '0)
                    fail_p0[i] = 1'b1;
            end
        end
    end

    // Stage p0 -> p1: history, counters, window FSMs and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            edge_p1 <= '0;
            pass_p1 <= '0;
            fail_p1 <= '0;
            err_p1  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state[i] <= IDLE;
                rem[i]   <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            edge_p1 <= det_p0;
            pass_p1 <= pass_p0;
            fail_p1 <= fail_p0;
            if (bus.sample_en)
                prev <= bus.sig_in;
            // A fail in the same cycle as a clear leaves the flag set.
            if (|fail_p0)
                err_p1 <= 1'b1;
            else if (bus.cnt_clr)
                err_p1 <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (bus.cnt_clr)
                    cnt[i] <= '0;
                else if (det_p0[i])
                    cnt[i] <= sat_inc(cnt[i]);
                case (state[i])
                    IDLE: begin
                        if (bus.arm[i]) begin
                            state[i] <= ARMED;
                            rem[i]   <= bus.win_len;
                        end
                    end
                    ARMED: begin
                        // arm is ignored here, so a window is never restarted.
                        if (pass_p0[i] | fail_p0[i])
                            state[i] <= IDLE;
                        else if (bus.sample_en)
                            rem[i] <= rem[i] - WIN_W'(1);
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    // Counter read mux; selects beyond the last channel read as zero.
    always_comb begin
        for (int i = 0; i < SEL_N; i++)
            cnt_pad[i] = '0;
        for (int i = 0; i < NCH; i++)
            cnt_pad[i] = cnt[i];
    end

    assign bus.cnt_o  = cnt_pad[bus.cnt_sel];
    assign bus.edge_o = edge_p1;
    assign bus.pass_o = pass_p1;
    assign bus.fail_o = fail_p1;
    assign bus.err_o  = err_p1;
endmodule
